// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the byte-lane memory: access sizes,
// control states, load extension and store byte-enable generation.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Upper bound on lanes; callers truncate the enable vector to their NB.
  localparam int MAX_NB = 64;

  function automatic logic [31:0] extend(input logic [31:0] data,
                                         input logic [1:0]  size,
                                         input logic        is_unsigned);
    logic [31:0] r;
    case (size)
      SZ_B:    r = {{24{data[7] & ~is_unsigned}}, data[7:0]};
      SZ_H:    r = {{16{data[15] & ~is_unsigned}}, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [MAX_NB-1:0] byte_enable(input logic [1:0] size,
                                                    input logic [5:0] lane);
    logic [MAX_NB-1:0] base;
    case (size)
      SZ_B:    base = MAX_NB'(1);
      SZ_H:    base = MAX_NB'(3);
      default: base = MAX_NB'(15);
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/byte_en_ram.sv
// Single-port word RAM with per-lane write enables and a registered read;
// one-cycle read latency, no backpressure (caller gates with en).
module byte_en_ram #(
  parameter int NB    = 4,
  parameter int IDX_W = 15
) (
  input  logic              clock,
  input  logic              en,
  input  logic [NB-1:0]     we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [NB*8-1:0]   wdata,
  output logic [NB*8-1:0]   rdata
);

  localparam int WORDS = 1 << IDX_W;

  logic [NB*8-1:0] mem_q [WORDS];
  logic [NB*8-1:0] rdata_q;

  // Read-before-write ordering; a store never returns data so it does not matter.
  always_ff @(posedge clock) begin
    if (en) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/byte_lane_memory.sv
// Handshaked byte-lane RAM for RV32I loads/stores; response LATENCY+1 cycles after accept cycle.
// One request in flight: req_ready only in IDLE, response held until rsp_ready.
module byte_lane_memory
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 17,
  parameter int          DATA_WIDTH = 32,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = ADDR_WIDTH - LANE_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic [31:0]           offset;
  logic                  misaligned;
  logic                  req_err;
  logic                  accept;
  logic [LANE_W-1:0]     lane;
  logic [IDX_W-1:0]      idx;
  logic [NB-1:0]         ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] shifted;
  logic [31:0]           ext32;
  logic [DATA_WIDTH-1:0] load_data;

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign accept    = req_valid && req_ready;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  always_comb begin
    offset     = req_addr - BASE_ADDR;
    misaligned = 1'b0;
    case (req_size)
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    req_err   = (req_size == 2'd3) || misaligned || ((offset >> ADDR_WIDTH) != 32'd0);
    lane      = offset[LANE_W-1:0];
    idx       = offset[ADDR_WIDTH-1:LANE_W];
    ram_we    = (accept && req_write && !req_err) ? NB'(byte_enable(req_size, 6'(lane))) : '0;
    ram_wdata = req_wdata << {lane, 3'b000};
  end

  byte_en_ram #(
    .NB    (NB),
    .IDX_W (IDX_W)
  ) u_ram (
    .clock (clock),
    .en    (accept),
    .we    (ram_we),
    .idx   (idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Word loads extend from bit 31 even when DATA_WIDTH is wider.
  always_comb begin
    shifted          = ram_rdata >> {lane_q, 3'b000};
    ext32            = extend(shifted[31:0], size_q, uns_q);
    load_data        = {DATA_WIDTH{ext32[31] & ~uns_q}};
    load_data[31:0]  = ext32;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    err_d       = err_q;
    write_d     = write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
          lane_d  = lane;
          size_d  = req_size;
          uns_d   = req_unsigned;
          err_d   = req_err;
          write_d = req_write;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_rdata_d = (err_q || write_q) ? '0 : load_data;
          rsp_error_d = err_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      write_q     <= write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule

// File: tb/tb_byte_lane_memory.sv
// Directed bench: one instance at LATENCY=1 for data/error paths, one at LATENCY=3
// for backpressure and reset-while-waiting.
module tb_byte_lane_memory;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst1, rst3;
  logic        vld1, vld3, rdy1, rdy3;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        req_ready1, req_ready3, rsp_valid1, rsp_valid3;
  logic        rsp_error1, rsp_error3;
  logic [31:0] rsp_rdata1, rsp_rdata3;

  logic        sel;
  logic        cur_ready, cur_valid, cur_error;
  logic [31:0] cur_rdata;

  assign cur_ready = sel ? req_ready3 : req_ready1;
  assign cur_valid = sel ? rsp_valid3 : rsp_valid1;
  assign cur_error = sel ? rsp_error3 : rsp_error1;
  assign cur_rdata = sel ? rsp_rdata3 : rsp_rdata1;

  byte_lane_memory #(.LATENCY(1)) u_dut1 (
    .clock        (clock),
    .reset        (rst1),
    .req_valid    (vld1),
    .req_ready    (req_ready1),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid1),
    .rsp_ready    (rdy1),
    .rsp_rdata    (rsp_rdata1),
    .rsp_error    (rsp_error1)
  );

  byte_lane_memory #(.LATENCY(3)) u_dut3 (
    .clock        (clock),
    .reset        (rst3),
    .req_valid    (vld3),
    .req_ready    (req_ready3),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid3),
    .rsp_ready    (rdy3),
    .rsp_rdata    (rsp_rdata3),
    .rsp_error    (rsp_error3)
  );

  int n_vec    = 0;
  int n_miscmp = 0;

  task automatic check_dat(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request on the selected instance and returns the response;
  // lat counts cycles from the accept cycle to the first cycle with rsp_valid.
  task automatic do_req(input logic s, input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd,
                        input logic hold_rsp,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clock);
    sel          = s;
    req_write    = w;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = u;
    req_wdata    = wd;
    rdy1         = !hold_rsp;
    rdy3         = !hold_rsp;
    if (s) vld3 = 1'b1;
    else   vld1 = 1'b1;
    n = 0;
    while (!cur_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_dat("req_ready_wait", 32'(cur_ready), 32'd1);
    @(posedge clock);
    #1;
    vld1 = 1'b0;
    vld3 = 1'b0;
    lat  = 1;
    @(negedge clock);
    while (!cur_valid && lat < 30) begin
      @(negedge clock);
      lat++;
    end
    check_dat("rsp_valid_wait", 32'(cur_valid), 32'd1);
    rd = cur_rdata;
    er = cur_error;
  endtask

  task automatic run_vec(input string tag, input logic s, input logic w, input logic [31:0] a,
                         input logic [1:0] sz, input logic u, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(s, w, a, sz, u, wd, 1'b0, rd, er, lat);
    check_dat({tag, ".rdata"}, rd, exp_d);
    check_dat({tag, ".error"}, 32'(er), 32'(exp_e));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    rst1 = 1'b1; rst3 = 1'b1;
    vld1 = 1'b0; vld3 = 1'b0; rdy1 = 1'b1; rdy3 = 1'b1;
    sel = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;

    repeat (3) @(negedge clock);
    check_dat("rst.req_ready", 32'(req_ready1), 32'd0);
    check_dat("rst.rsp_valid", 32'(rsp_valid1), 32'd0);
    check_dat("rst.rsp_rdata", rsp_rdata1, 32'd0);
    check_dat("rst.rsp_error", 32'(rsp_error1), 32'd0);
    check_dat("rst.req_ready3", 32'(req_ready3), 32'd0);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clock);
    check_dat("post_rst.req_ready", 32'(req_ready1), 32'd1);

    // LATENCY=1 data path
    run_vec("sw_100", 1'b0, 1'b1, 32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_req(1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0, rd, er, lat);
    check_dat("lw_100.rdata", rd, 32'hDEAD_BEEF);
    check_dat("lw_100.error", 32'(er), 32'd0);
    check_dat("lw_100.latency", 32'(lat), 32'd2);
    run_vec("lb_103",  1'b0, 1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0);
    run_vec("lbu_103", 1'b0, 1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 32'h0000_00DE, 1'b0);
    run_vec("lh_100",  1'b0, 1'b0, 32'h100, 2'd1, 1'b0, 32'h0, 32'hFFFF_BEEF, 1'b0);
    run_vec("lhu_102", 1'b0, 1'b0, 32'h102, 2'd1, 1'b1, 32'h0, 32'h0000_DEAD, 1'b0);
    run_vec("sb_101",  1'b0, 1'b1, 32'h101, 2'd0, 1'b0, 32'hAAAA_AA55, 32'h0, 1'b0);
    run_vec("lw_sb",   1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0);
    run_vec("sw_102_mis", 1'b0, 1'b1, 32'h102, 2'd2, 1'b0, 32'h1111_1111, 32'h0, 1'b1);
    run_vec("lh_101_mis", 1'b0, 1'b0, 32'h101, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
    run_vec("lw_unchg",   1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b1 & 1'b0);
    run_vec("lw_oor",     1'b0, 1'b0, 32'h0002_0000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    run_vec("sw_oor",     1'b0, 1'b1, 32'h0002_0100, 2'd2, 1'b0, 32'h7777_7777, 32'h0, 1'b1);
    run_vec("lw_alias",   1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0);
    run_vec("size3",      1'b0, 1'b0, 32'h100, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    run_vec("sw_top",     1'b0, 1'b1, 32'h0001_FFFC, 2'd2, 1'b0, 32'h0BAD_CAFE, 32'h0, 1'b0);
    run_vec("lw_top",     1'b0, 1'b0, 32'h0001_FFFC, 2'd2, 1'b0, 32'h0, 32'h0BAD_CAFE, 1'b0);
    run_vec("sh_106",     1'b0, 1'b1, 32'h106, 2'd1, 1'b0, 32'hFFFF_8001, 32'h0, 1'b0);
    run_vec("lh_106",     1'b0, 1'b0, 32'h106, 2'd1, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0);
    run_vec("lbu_107",    1'b0, 1'b0, 32'h107, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 1'b0);
    run_vec("lb_106",     1'b0, 1'b0, 32'h106, 2'd0, 1'b0, 32'h0, 32'h0000_0001, 1'b0);

    // LATENCY=3: backpressure
    run_vec("l3.sw_40", 1'b1, 1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b1, rd, er, lat);
    check_dat("l3.latency", 32'(lat), 32'd4);
    check_dat("l3.rdata", rd, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_dat("l3.hold.rsp_valid", 32'(rsp_valid3), 32'd1);
      check_dat("l3.hold.rsp_rdata", rsp_rdata3, 32'hCAFE_F00D);
      check_dat("l3.hold.rsp_error", 32'(rsp_error3), 32'd0);
      check_dat("l3.hold.req_ready", 32'(req_ready3), 32'd0);
    end
    rdy3 = 1'b1;
    @(negedge clock);
    check_dat("l3.release.req_ready", 32'(req_ready3), 32'd1);
    check_dat("l3.release.rsp_valid", 32'(rsp_valid3), 32'd0);

    // LATENCY=3: reset while waiting drops the response but keeps the store
    @(negedge clock);
    sel = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h1234_5678; rdy3 = 1'b1; vld3 = 1'b1;
    seen = 0;
    while (!req_ready3 && seen < 20) begin
      @(negedge clock);
      seen++;
    end
    @(posedge clock);
    #1 vld3 = 1'b0;
    @(negedge clock);
    rst3 = 1'b1;
    repeat (2) @(negedge clock);
    rst3 = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rsp_valid3) seen++;
    end
    check_dat("l3.rst_wait.no_rsp", 32'(seen), 32'd0);
    run_vec("l3.lw_200", 1'b1, 1'b0, 32'h200, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
